digit_entry_buffer: RTL and testbench

//  Parametrised keypad digit-entry store. Takes a one-hot-ish keypad vector and priority-encodes it.

---
 rtl/digit_entry_buffer_pkg.sv | 22 ++
 rtl/digit_entry_buffer_key_priority_encoder.sv | 20 ++
 rtl/digit_entry_buffer.sv | 131 +++++++++++++
 tb/tb_digit_entry_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_buffer_pkg.sv
// Shared types for the keypad digit-entry buffer: entry modes and press-tracking FSM states.
package digit_entry_buffer_pkg;

  typedef enum logic [1:0] {
    ModeLock   = 2'b00,
    ModeEnterR = 2'b01,
    ModeEnterL = 2'b10,
    ModePload  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StDebounce = 2'b01,
    StCommit   = 2'b10,
    StWaitRel  = 2'b11
  } state_e;

  function automatic logic is_enter(mode_e m);
    return (m == ModeEnterR) || (m == ModeEnterL);
  endfunction

endpackage

// File: rtl/digit_entry_buffer_key_priority_encoder.sv
// Combinational keypad encoder: the highest asserted line wins; any flags a pressed key.
module key_priority_encoder #(
  parameter int unsigned NUM_KEYS = 10,
  parameter int unsigned DIGIT_W  = 4
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic [DIGIT_W-1:0]  code,
  output logic                any
);

  always_comb begin
    code = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (keys[i]) code = DIGIT_W'(i);
    end
  end

  assign any = |keys;

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit-entry store: synchronise, debounce and encode presses, then commit one digit per
// press into a DEPTH-slot shift store with backspace, clear and parallel load.
module digit_entry_buffer
  import digit_entry_buffer_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 10,
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_KEYS-1:0]          key_in,
  input  logic [1:0]                   mode,
  input  logic                         clear,
  input  logic                         backspace,
  input  logic                         load_en,
  input  logic [DEPTH*DIGIT_W-1:0]     load_data,
  output logic [DEPTH*DIGIT_W-1:0]     digits_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         key_valid,
  output logic [DIGIT_W-1:0]           key_code,
  output logic                         overflow
);

  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned SlotsW = DEPTH * DIGIT_W;

  logic [NUM_KEYS-1:0] ks_meta, ks;
  logic [DIGIT_W-1:0]  enc_code;
  logic                enc_any;

  // Synchroniser is left out of reset so a key held through reset still reads as held.
  always_ff @(posedge clk) begin
    ks_meta <= key_in;
    ks      <= ks_meta;
  end

  key_priority_encoder #(
    .NUM_KEYS (NUM_KEYS),
    .DIGIT_W  (DIGIT_W)
  ) u_enc (
    .keys (ks),
    .code (enc_code),
    .any  (enc_any)
  );

  state_e             state_q;
  logic [DbW-1:0]     db_cnt_q;
  logic [DIGIT_W-1:0] cap_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitRel;
      db_cnt_q   <= '0;
      cap_code_q <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enc_any) begin
            cap_code_q <= enc_code;
            db_cnt_q   <= '0;
            state_q    <= StDebounce;
          end
        end
        StDebounce: begin
          if (!enc_any || (enc_code != cap_code_q)) begin
            state_q <= StIdle;
          end else if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
            state_q   <= StCommit;
            key_valid <= 1'b1;
            key_code  <= cap_code_q;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        StCommit:  state_q <= StWaitRel;
        StWaitRel: if (!enc_any) state_q <= StIdle;
        default:   state_q <= StWaitRel;
      endcase
    end
  end

  mode_e             mode_sel;
  logic              enter_mode;
  logic [SlotsW-1:0] slots_q;
  logic [CountW-1:0] count_q;

  assign mode_sel   = mode_e'(mode);
  assign enter_mode = is_enter(mode_sel);
  assign full       = (count_q == CountW'(DEPTH));
  assign empty      = (count_q == '0);

  // A commit in an entry mode consumes the cycle even when full, so a same-cycle backspace drops.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slots_q <= '0;
      count_q <= '0;
    end else if ((mode_sel == ModePload) && load_en) begin
      slots_q <= load_data;
      count_q <= CountW'(DEPTH);
    end else if (key_valid && enter_mode) begin
      if (!full) begin
        if (mode_sel == ModeEnterL) begin
          slots_q <= {slots_q[SlotsW-DIGIT_W-1:0], key_code};
        end else begin
          slots_q <= {key_code, slots_q[SlotsW-1:DIGIT_W]};
        end
        count_q <= count_q + 1'b1;
      end
    end else if (backspace && enter_mode && !empty) begin
      if (mode_sel == ModeEnterL) begin
        slots_q <= {{DIGIT_W{1'b0}}, slots_q[SlotsW-1:DIGIT_W]};
      end else begin
        slots_q <= {slots_q[SlotsW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
      end
      count_q <= count_q - 1'b1;
    end
  end

  assign overflow   = key_valid && enter_mode && full && !clear && !rst;
  assign digits_out = slots_q;
  assign count      = count_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: directed press sequences, an encoder vector table and a random
// mix of presses, backspaces, clears and loads against a queue-based slot model.
module tb_digit_entry_buffer;

  localparam int NK = 10;
  localparam int DW = 4;
  localparam int DP = 4;
  localparam int DB = 4;

  logic              clk, rst;
  logic [NK-1:0]     key_in;
  logic [1:0]        mode;
  logic              clear, backspace, load_en;
  logic [DP*DW-1:0]  load_data;
  logic [DP*DW-1:0]  digits_out;
  logic [2:0]        count;
  logic              full, empty, key_valid, overflow;
  logic [DW-1:0]     key_code;

  digit_entry_buffer #(
    .NUM_KEYS     (NK),
    .DIGIT_W      (DW),
    .DEPTH        (DP),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .mode       (mode),
    .clear      (clear),
    .backspace  (backspace),
    .load_en    (load_en),
    .load_data  (load_data),
    .digits_out (digits_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int ov_cnt   = 0;
  int m[$];
  int mcnt;
  int last_code;

  typedef struct {
    logic [NK-1:0] keys;
    logic [DW-1:0] code;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    kv_cnt += int'(key_valid);
    ov_cnt += int'(overflow);
  endtask

  task automatic press(input logic [NK-1:0] k, input int h);
    key_in = k;
    repeat (h) tick();
    key_in = '0;
    repeat (6) tick();
  endtask

  function automatic int top_key(logic [NK-1:0] k);
    for (int i = NK - 1; i >= 0; i--) if (k[i]) return i;
    return 0;
  endfunction

  function automatic void m_clear();
    m.delete();
    repeat (DP) m.push_back(0);
    mcnt = 0;
  endfunction

  // Returns 1 when the commit should be dropped as an overflow.
  function automatic bit m_commit(int code, int md);
    if (md != 1 && md != 2) return 1'b0;
    if (mcnt == DP) return 1'b1;
    if (md == 2) begin
      m.push_front(code);
      void'(m.pop_back());
    end else begin
      m.push_back(code);
      void'(m.pop_front());
    end
    mcnt++;
    return 1'b0;
  endfunction

  function automatic void m_back(int md);
    if ((md != 1 && md != 2) || mcnt == 0) return;
    if (md == 2) begin
      void'(m.pop_front());
      m.push_back(0);
    end else begin
      void'(m.pop_back());
      m.push_front(0);
    end
    mcnt--;
  endfunction

  function automatic logic [DP*DW-1:0] m_pack();
    logic [DP*DW-1:0] r;
    for (int k = 0; k < DP; k++) r[k*DW +: DW] = DW'(m[k]);
    return r;
  endfunction

  task automatic check_state(input string name);
    chk({name, " digits"}, 32'(digits_out), 32'(m_pack()));
    chk({name, " count"}, 32'(count), 32'(mcnt));
    chk({name, " full"}, 32'(full), 32'(mcnt == DP));
    chk({name, " empty"}, 32'(empty), 32'(mcnt == 0));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
  endtask

  task automatic do_back(input int md);
    mode = 2'(md);
    backspace = 1'b1;
    tick();
    backspace = 1'b0;
    tick();
    m_back(md);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int md, h, op;
    bit exp_ov;
    logic [NK-1:0] k;

    vecs[0] = '{keys: 10'b00_0000_0001, code: 4'd0};
    vecs[1] = '{keys: 10'b10_0000_0000, code: 4'd9};
    vecs[2] = '{keys: 10'b00_0000_0101, code: 4'd2};
    vecs[3] = '{keys: 10'b01_0001_0000, code: 4'd8};
    vecs[4] = '{keys: 10'b11_1111_1111, code: 4'd9};
    vecs[5] = '{keys: 10'b00_0010_0000, code: 4'd5};

    rst = 1'b1; key_in = '0; mode = 2'd0; clear = 1'b0; backspace = 1'b0;
    load_en = 1'b0; load_data = '0;
    m_clear();
    last_code = 0;
    repeat (3) tick();
    chk("reset digits", 32'(digits_out), 32'h0);
    chk("reset count", 32'(count), 32'h0);
    chk("reset empty", 32'(empty), 32'h1);
    chk("reset full", 32'(full), 32'h0);
    chk("reset key_valid", 32'(key_valid), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    chk("reset key_code", 32'(key_code), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // 1: latency of a single press
    mode = 2'd2;
    key_in = NK'(1) << 7;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("t1 key_valid E%0d", e), 32'(key_valid), 32'(e == DB + 2));
    end
    chk("t1 slot0", 32'(digits_out[3:0]), 32'h7);
    chk("t1 count", 32'(count), 32'h1);
    void'(m_commit(7, 2));
    key_in = '0;
    repeat (6) tick();

    // 2: a short key 3 replaced by key 5 commits once, as 5
    kv_cnt = 0;
    key_in = NK'(1) << 3;
    repeat (3) tick();
    key_in = NK'(1) << 5;
    repeat (10) tick();
    key_in = '0;
    repeat (6) tick();
    chk("t2 kv count", 32'(kv_cnt), 32'h1);
    chk("t2 key_code", 32'(key_code), 32'h5);
    void'(m_commit(5, 2));
    check_state("t2");

    // 3: fill from the left, then overflow
    do_clear();
    mode = 2'd2;
    for (int d = 1; d <= 4; d++) begin
      press(NK'(1) << d, DB + 2);
      void'(m_commit(d, 2));
    end
    chk("t3 digits", 32'(digits_out), 32'h1234);
    kv_cnt = 0; ov_cnt = 0;
    press(NK'(1) << 9, DB + 2);
    chk("t3 overflow pulses", 32'(ov_cnt), 32'(m_commit(9, 2)));
    chk("t3 kv pulses", 32'(kv_cnt), 32'h1);
    check_state("t3");

    // 4: right entry and backspace down past empty
    do_clear();
    mode = 2'd1;
    press(NK'(1) << 1, DB + 2);
    press(NK'(1) << 2, DB + 2);
    void'(m_commit(1, 1));
    void'(m_commit(2, 1));
    chk("t4 digits", 32'(digits_out), 32'h2100);
    do_back(1);
    chk("t4 bs digits", 32'(digits_out), 32'h1000);
    chk("t4 bs count", 32'(count), 32'h1);
    do_back(1);
    do_back(1);
    chk("t4 empty", 32'(empty), 32'h1);
    check_state("t4");

    // 5: two keys encode to the higher; a key held through reset does not commit
    do_clear();
    mode = 2'd2;
    kv_cnt = 0;
    press((NK'(1) << 2) | (NK'(1) << 8), DB + 2);
    chk("t5 key_code", 32'(key_code), 32'h8);
    void'(m_commit(8, 2));
    kv_cnt = 0;
    key_in = (NK'(1) << 2) | (NK'(1) << 8);
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_clear();
    repeat (10) tick();
    key_in = '0;
    repeat (6) tick();
    chk("t5 held through reset kv", 32'(kv_cnt), 32'h0);
    chk("t5 key_code after reset", 32'(key_code), 32'h0);
    press(NK'(1) << 4, DB + 2);
    void'(m_commit(4, 2));
    chk("t5 digits", 32'(digits_out), 32'h0004);
    check_state("t5");

    // 6: clear beats load; then load; LOCK press leaves slots alone
    mode = 2'd3;
    load_data = 16'h9876;
    load_en = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6 clear wins digits", 32'(digits_out), 32'h0);
    chk("t6 clear wins count", 32'(count), 32'h0);
    tick();
    load_en = 1'b0;
    chk("t6 load digits", 32'(digits_out), 32'h9876);
    chk("t6 load count", 32'(count), 32'h4);
    for (int s = 0; s < DP; s++) m[s] = int'(load_data[s*DW +: DW]);
    mcnt = DP;
    mode = 2'd0;
    kv_cnt = 0;
    press(NK'(1) << 3, DB + 2);
    chk("t6 lock kv", 32'(kv_cnt), 32'h1);
    chk("t6 lock key_code", 32'(key_code), 32'h3);
    check_state("t6");

    // Encoder table, applied as presses in LOCK
    mode = 2'd0;
    foreach (vecs[i]) begin
      kv_cnt = 0;
      press(vecs[i].keys, DB + 2);
      chk($sformatf("tbl%0d kv", i), 32'(kv_cnt), 32'h1);
      chk($sformatf("tbl%0d code", i), 32'(key_code), 32'(vecs[i].code));
    end
    last_code = int'(vecs[5].code);
    check_state("tbl");

    // Random mix
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 9));
      md = int'($urandom_range(0, 3));
      if (op <= 5) begin
        mode = 2'(md);
        k = NK'($urandom_range(1, (1 << NK) - 1));
        h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DB))
                                         : int'($urandom_range(DB + 1, DB + 6));
        kv_cnt = 0; ov_cnt = 0;
        press(k, h);
        exp_ov = 1'b0;
        if (h > DB) begin
          last_code = top_key(k);
          exp_ov = m_commit(last_code, md);
        end
        chk($sformatf("rnd%0d kv", it), 32'(kv_cnt), 32'(h > DB));
        chk($sformatf("rnd%0d ov", it), 32'(ov_cnt), 32'(exp_ov));
        chk($sformatf("rnd%0d code", it), 32'(key_code), 32'(last_code));
      end else if (op == 6 || op == 7) begin
        do_back(md);
      end else if (op == 8) begin
        do_clear();
      end else begin
        mode = 2'd3;
        load_data = 16'($urandom);
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        for (int s = 0; s < DP; s++) m[s] = int'(load_data[s*DW +: DW]);
        mcnt = DP;
      end
      check_state($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
